// File: rtl/counter_pkg.sv
// counter_pkg: shared constants and helpers for the rate-divided counters.
//   DIV_SLOW_DEF / DIV_FAST_DEF : default clocks per count step (slow / fast rate)
//   dir_e                       : count direction encoding of the control input
//   max2()                      : larger of two ints, used to size the prescaler
package counter_pkg;

    localparam int DIV_SLOW_DEF = 25000000;
    localparam int DIV_FAST_DEF = 250000;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: one shared prescaler counting 0..DIV-1 for the selected rate.
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset, clears the count
//   en      : advance enable; 0 holds the count
//   clr     : restart to 0 with no step (load or rate change); beats a step
//   div_sel : 0 = DIV_SLOW, 1 = DIV_FAST
//   step    : combinational, high on the edge where the count wraps
module tick_prescaler
    import counter_pkg::*;
#(
    parameter int DIV_SLOW = DIV_SLOW_DEF,
    parameter int DIV_FAST = DIV_FAST_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    input  logic div_sel,
    output logic step
);

    localparam int PW = $clog2(max2(DIV_SLOW, DIV_FAST));
    localparam logic [PW-1:0] LAST_SLOW = PW'(DIV_SLOW - 1);
    localparam logic [PW-1:0] LAST_FAST = PW'(DIV_FAST - 1);

    logic [PW-1:0] cnt;
    logic [PW-1:0] last;
    logic          at_last;

    assign last    = div_sel ? LAST_FAST : LAST_SLOW;
    assign at_last = (cnt == last);
    // A restart swallows a step that would otherwise land on the same edge.
    assign step    = en & ~clr & at_last;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= at_last ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/updown_rate_counter.sv
// updown_rate_counter: up/down counter stepped at one of two prescaled rates.
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset
//   en       : count enable; 0 freezes prescaler and count (load still works)
//   hz       : rate select, 0 = DIV_SLOW, 1 = DIV_FAST; a change restarts the prescaler
//   control  : direction, 0 = up, 1 = down
//   sat      : boundary mode, 0 = wrap, 1 = saturate
//   load     : synchronous load of load_val (clamped to MAX_VAL); beats a step
//   load_val : value to load
//   out      : registered count
//   tick     : one-cycle strobe in the cycle a step has been applied to out
//   tc       : one-cycle strobe alongside tick when the step was taken at a boundary
module updown_rate_counter
    import counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int DIV_SLOW = DIV_SLOW_DEF,
    parameter int DIV_FAST = DIV_FAST_DEF,
    parameter int MAX_VAL  = 2**WIDTH - 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             hz,
    input  logic             control,
    input  logic             sat,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] out,
    output logic             tick,
    output logic             tc
);

    if (DIV_SLOW < 2) begin : g_bad_div_slow
        $fatal(1, "DIV_SLOW must be at least 2");
    end
    if (DIV_FAST < 2) begin : g_bad_div_fast
        $fatal(1, "DIV_FAST must be at least 2");
    end
    if (MAX_VAL > 2**WIDTH - 1) begin : g_bad_max_val
        $fatal(1, "MAX_VAL does not fit in WIDTH bits");
    end

    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_VAL);

    logic             hz_q;
    logic             hz_chg;
    logic             step;
    logic             at_bound;
    dir_e             dir;
    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] load_clamped;

    // hz history is just the previous hz; reset loads it with the live value
    // so releasing reset never looks like a rate change.
    always_ff @(posedge clk) begin
        hz_q <= hz;
    end
    assign hz_chg = hz ^ hz_q;

    tick_prescaler #(
        .DIV_SLOW (DIV_SLOW),
        .DIV_FAST (DIV_FAST)
    ) u_prescaler (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .clr     (load | hz_chg),
        .div_sel (hz),
        .step    (step)
    );

    assign dir          = dir_e'(control);
    assign at_bound     = (dir == DIR_UP) ? (out == MAXV) : (out == '0);
    assign load_clamped = (load_val > MAXV) ? MAXV : load_val;

    always_comb begin
        nxt = out;
        if (at_bound) begin
            if (!sat) nxt = (dir == DIR_UP) ? '0 : MAXV;
        end else begin
            nxt = (dir == DIR_UP) ? out + 1'b1 : out - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out  <= '0;
            tick <= 1'b0;
            tc   <= 1'b0;
        end else if (load) begin
            out  <= load_clamped;
            tick <= 1'b0;
            tc   <= 1'b0;
        end else if (step) begin
            out  <= nxt;
            tick <= 1'b1;
            tc   <= at_bound;
        end else begin
            tick <= 1'b0;
            tc   <= 1'b0;
        end
    end

endmodule

// File: doc/updown_rate_counter.md
UPDOWN_RATE_COUNTER -- requirements
Module: updown_rate_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, count register width in bits.
REQ-002 SHALL have parameter DIV_SLOW, default 25000000, clocks per count step when hz=0.
REQ-003 SHALL have parameter DIV_FAST, default 250000, clocks per count step when hz=1.
REQ-004 SHALL have parameter MAX_VAL, default 2**WIDTH-1, top of count range; MAX_VAL <= 2**WIDTH-1.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port en  input  1  count enable; 0 freezes prescaler and count.
REQ-008 SHALL have port hz  input  1  rate select: 0 = DIV_SLOW, 1 = DIV_FAST.
REQ-009 SHALL have port control  input  1  direction: 0 = up, 1 = down.
REQ-010 SHALL have port sat  input  1  boundary mode: 0 = wrap, 1 = saturate.
REQ-011 SHALL have port load  input  1  synchronous load strobe.
REQ-012 SHALL have port load_val  input  WIDTH  value written on load; values > MAX_VAL clamp to MAX_VAL.
REQ-013 SHALL have port out  output  WIDTH  registered count value.
REQ-014 SHALL have port tick  output  1  registered one-cycle strobe, high in the cycle a step is applied to out.
REQ-015 SHALL have port tc  output  1  registered one-cycle terminal-count strobe.

Function
REQ-016 SHALL use one shared prescaler counter, width $clog2(max(DIV_SLOW,DIV_FAST)), counting 0..DIV-1 for the selected DIV.
REQ-017 SHALL generate an internal step when en=1 and prescaler == DIV-1; prescaler returns to 0 on that edge.
REQ-018 SHALL clear the prescaler to 0, with no step, on the edge after any change of hz (hz registered one stage for edge detect).
REQ-019 SHALL apply a step to out on the same edge the step is generated; tick is high for exactly the following cycle.
REQ-020 Up step: out+1 if out < MAX_VAL; at MAX_VAL wrap to 0 (sat=0) or hold MAX_VAL (sat=1).
REQ-021 Down step: out-1 if out > 0; at 0 wrap to MAX_VAL (sat=0) or hold 0 (sat=1).
REQ-022 SHALL pulse tc for one cycle, coincident with tick, on every step taken at a boundary (MAX_VAL up, 0 down), in both modes.
REQ-023 load=1 SHALL write clamped load_val to out and clear prescaler on that edge; load has priority over a coincident step; tick and tc stay 0.
REQ-024 en=0 SHALL hold out and prescaler; load still acts while en=0.
REQ-025 control, sat changes SHALL take effect at the next step, no prescaler restart.
REQ-026 Priority per edge: rst > load > hz-change restart > step.

Reset
REQ-027 rst=1 at a rising edge SHALL set out=0, prescaler=0, tick=0, tc=0, hz history=current hz.
REQ-028 Reset mid-count SHALL discard any partial prescaler progress; first step after release occurs DIV clocks after the first edge with rst=0 and en=1.

Structure
REQ-029 Default DIV_SLOW/DIV_FAST constants and a max-of-two helper SHALL live in shared package counter_pkg.
REQ-030 Prescaler SHALL be a sub-module tick_prescaler (inputs clk, rst, en, clr, div_sel; output step).
REQ-031 Elaboration SHALL fail for DIV_SLOW < 2, DIV_FAST < 2, or MAX_VAL > 2**WIDTH-1.

Verification (WIDTH=4, DIV_SLOW=10, DIV_FAST=3, MAX_VAL=15 unless stated)
REQ-032 rst, then en=1, hz=1, control=0, sat=0 for 48 clocks -> out steps every 3 clocks, 15 wraps to 0 with tc pulse, tick count 16.
REQ-033 load_val=1, load, then control=1, sat=1, hz=0 -> out 1, 0 after 10 clocks, then holds 0 with tc on each further tick.
REQ-034 MAX_VAL=9, sat=0, up from load 8 -> 9, 0 (tc), 1; load_val=12 -> out=9.
REQ-035 Toggle hz at prescaler=2 of DIV_SLOW -> no step, next step exactly DIV_FAST clocks after restart edge.
REQ-036 load asserted on step edge -> out=load_val, tick=0; en=0 for 20 clocks -> out constant, no tick.
REQ-037 rst at prescaler=7, hz=0 -> out=0, first step 10 clocks after release.
